// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - instruction-in / immediate-out handshake bundle for imm_gen_pipe
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_ir;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  // master = fetch-queue/consumer side, slave = the immediate generator
  modport master (
    output in_valid, in_ir, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal
  );

  modport slave (
    input  in_valid, in_ir, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined RV32I/RV64I immediate generator with 2-entry skid buffer
module imm_gen_pipe #(
  parameter int XLEN    = 32,
  parameter bit ZIMM_EN = 1'b1
) (
  input logic          clk,
  input logic          rst,
  imm_gen_pipe_if.slave bus
);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
  localparam logic [2:0] FMT_ZIMM  = 3'd7;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_IMM_32   = 7'b0011011;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  logic [31:0]     ir;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [63:0]     d_imm64;
  logic [XLEN-1:0] d_imm;
  logic [2:0]      d_fmt;
  logic            d_ill;

  assign ir     = bus.in_ir;
  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];

  // Everything is built at 64 bits and truncated, so one source serves both widths.
  always_comb begin
    d_imm64 = 64'h0;
    d_fmt   = FMT_NONE;
    d_ill   = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        d_imm64 = {{32{ir[31]}}, ir[31:12], 12'h000};
        d_fmt   = FMT_U;
      end
      OP_JAL: begin
        d_imm64 = {{44{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
        d_fmt   = FMT_J;
      end
      OP_BRANCH: begin
        d_imm64 = {{52{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
        d_fmt   = FMT_B;
      end
      OP_STORE: begin
        d_imm64 = {{52{ir[31]}}, ir[31:25], ir[11:7]};
        d_fmt   = FMT_S;
      end
      OP_JALR, OP_LOAD: begin
        d_imm64 = {{52{ir[31]}}, ir[31:20]};
        d_fmt   = FMT_I;
      end
      OP_IMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          d_imm64 = {58'h0, ir[25:20]};
          d_fmt   = FMT_SHAMT;
          d_ill   = (XLEN == 32) && ir[25];
        end else begin
          d_imm64 = {{52{ir[31]}}, ir[31:20]};
          d_fmt   = FMT_I;
        end
      end
      OP_IMM_32: begin
        // Word-shift opcodes do not exist on RV32 and fall through as unrecognised.
        if (XLEN == 64) begin
          if (funct3 == 3'b001 || funct3 == 3'b101) begin
            d_imm64 = {59'h0, ir[24:20]};
            d_fmt   = FMT_SHAMT;
            d_ill   = ir[25];
          end else begin
            d_imm64 = {{52{ir[31]}}, ir[31:20]};
            d_fmt   = FMT_I;
          end
        end
      end
      OP_SYSTEM: begin
        if (ZIMM_EN && funct3[2]) begin
          d_imm64 = {59'h0, ir[19:15]};
          d_fmt   = FMT_ZIMM;
        end
      end
      default: begin
        d_imm64 = 64'h0;
        d_fmt   = FMT_NONE;
        d_ill   = 1'b0;
      end
    endcase
  end

  assign d_imm = d_imm64[XLEN-1:0];

  logic            mv;
  logic [XLEN-1:0] m_imm;
  logic [2:0]      m_fmt;
  logic            m_ill;
  logic            kv;
  logic [XLEN-1:0] k_imm;
  logic [2:0]      k_fmt;
  logic            k_ill;
  logic            accept;

  assign accept = bus.in_valid && !kv;

  // kv implies mv, so the skid slot only fills while M is held by backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mv    <= 1'b0;
      m_imm <= '0;
      m_fmt <= FMT_NONE;
      m_ill <= 1'b0;
      kv    <= 1'b0;
      k_imm <= '0;
      k_fmt <= FMT_NONE;
      k_ill <= 1'b0;
    end else if (kv) begin
      if (bus.out_ready) begin
        m_imm <= k_imm;
        m_fmt <= k_fmt;
        m_ill <= k_ill;
        kv    <= 1'b0;
      end
    end else if (accept && (!mv || bus.out_ready)) begin
      m_imm <= d_imm;
      m_fmt <= d_fmt;
      m_ill <= d_ill;
      mv    <= 1'b1;
    end else if (accept) begin
      k_imm <= d_imm;
      k_fmt <= d_fmt;
      k_ill <= d_ill;
      kv    <= 1'b1;
    end else if (mv && bus.out_ready) begin
      mv <= 1'b0;
    end
  end

  assign bus.in_ready    = !kv;
  assign bus.out_valid   = mv;
  assign bus.out_imm     = m_imm;
  assign bus.out_fmt     = m_fmt;
  assign bus.out_illegal = m_ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe across XLEN/ZIMM_EN variants
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_ir;
  logic        out_ready;

  int errors = 0;
  int checks = 0;
  int dut_acc = 0;
  int dut_out = 0;
  logic [31:0] q[$];

  imm_gen_pipe_if #(.XLEN(32)) if32  ();
  imm_gen_pipe_if #(.XLEN(64)) if64  ();
  imm_gen_pipe_if #(.XLEN(32)) if32n ();

  assign if32.in_valid   = in_valid;
  assign if32.in_ir      = in_ir;
  assign if32.out_ready  = out_ready;
  assign if64.in_valid   = in_valid;
  assign if64.in_ir      = in_ir;
  assign if64.out_ready  = out_ready;
  assign if32n.in_valid  = in_valid;
  assign if32n.in_ir     = in_ir;
  assign if32n.out_ready = out_ready;

  imm_gen_pipe #(.XLEN(32), .ZIMM_EN(1'b1)) u32  (.clk(clk), .rst(rst), .bus(if32));
  imm_gen_pipe #(.XLEN(64), .ZIMM_EN(1'b1)) u64  (.clk(clk), .rst(rst), .bus(if64));
  imm_gen_pipe #(.XLEN(32), .ZIMM_EN(1'b0)) u32n (.clk(clk), .rst(rst), .bus(if32n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode: immediates computed as signed integers from field weights.
  function automatic void ref_dec(input logic [31:0] ir, input int xl, input bit zen,
                                  output logic [63:0] imm, output logic [2:0] fmt,
                                  output logic ill);
    longint sir = longint'($signed(ir));
    longint v = 0;
    logic [2:0] f3 = ir[14:12];
    fmt = 3'd0;
    ill = 1'b0;
    case (ir[6:0])
      7'b0110111, 7'b0010111: begin fmt = 3'd4; v = sir & ~longint'(64'hFFF); end
      7'b1101111: begin
        fmt = 3'd5;
        v = -(longint'(ir[31]) << 20) + (longint'(ir[19:12]) << 12)
            + (longint'(ir[20]) << 11) + (longint'(ir[30:21]) << 1);
      end
      7'b1100011: begin
        fmt = 3'd3;
        v = -(longint'(ir[31]) << 12) + (longint'(ir[7]) << 11)
            + (longint'(ir[30:25]) << 5) + (longint'(ir[11:8]) << 1);
      end
      7'b0100011: begin fmt = 3'd2; v = (sir >>> 25) * 32 + longint'(ir[11:7]); end
      7'b1100111, 7'b0000011: begin fmt = 3'd1; v = sir >>> 20; end
      7'b0010011: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          fmt = 3'd6; v = longint'(ir[25:20]); ill = (xl == 32) && ir[25];
        end else begin
          fmt = 3'd1; v = sir >>> 20;
        end
      end
      7'b0011011: begin
        if (xl == 64) begin
          if (f3 == 3'd1 || f3 == 3'd5) begin
            fmt = 3'd6; v = longint'(ir[24:20]); ill = ir[25];
          end else begin
            fmt = 3'd1; v = sir >>> 20;
          end
        end
      end
      7'b1110011: begin
        if (zen && f3[2]) begin fmt = 3'd7; v = longint'(ir[19:15]); end
      end
      default: v = 0;
    endcase
    imm = (xl == 32) ? {32'h0, v[31:0]} : 64'(v);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cmp_dut(input string nm, input int xl, input bit zen,
                         input logic ov, input logic ir_, input logic [63:0] oimm,
                         input logic [2:0] ofmt, input logic oill,
                         input logic ev, input logic er);
    logic [63:0] ei;
    logic [2:0]  ef;
    logic        el;
    chk({nm, ".out_valid"}, 64'(ov), 64'(ev));
    chk({nm, ".in_ready"}, 64'(ir_), 64'(er));
    if (ev) begin
      ref_dec(q[0], xl, zen, ei, ef, el);
      chk({nm, ".imm"}, oimm, ei);
      chk({nm, ".fmt"}, 64'(ofmt), 64'(ef));
      chk({nm, ".illegal"}, 64'(oill), 64'(el));
    end
  endtask

  task automatic drive_cycle(input logic v, input logic [31:0] ir, input logic ordy);
    logic ev, er;
    @(negedge clk);
    in_valid  = v;
    in_ir     = ir;
    out_ready = ordy;
    #1;
    ev = (q.size() > 0);
    er = (q.size() < 2);
    cmp_dut("x32",  32, 1'b1, if32.out_valid,  if32.in_ready,  {32'h0, if32.out_imm},
            if32.out_fmt,  if32.out_illegal,  ev, er);
    cmp_dut("x64",  64, 1'b1, if64.out_valid,  if64.in_ready,  if64.out_imm,
            if64.out_fmt,  if64.out_illegal,  ev, er);
    cmp_dut("x32n", 32, 1'b0, if32n.out_valid, if32n.in_ready, {32'h0, if32n.out_imm},
            if32n.out_fmt, if32n.out_illegal, ev, er);
    if (v && if32.in_ready) dut_acc++;
    if (if32.out_valid && ordy) dut_out++;
    if (ev && ordy) void'(q.pop_front());
    if (v && er) q.push_back(ir);
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, ".x32.out_valid"},  64'(if32.out_valid), 64'h0);
    chk({tag, ".x32.in_ready"},   64'(if32.in_ready), 64'h1);
    chk({tag, ".x32.imm"},        64'(if32.out_imm), 64'h0);
    chk({tag, ".x32.fmt"},        64'(if32.out_fmt), 64'h0);
    chk({tag, ".x32.illegal"},    64'(if32.out_illegal), 64'h0);
    chk({tag, ".x64.out_valid"},  64'(if64.out_valid), 64'h0);
    chk({tag, ".x64.in_ready"},   64'(if64.in_ready), 64'h1);
    chk({tag, ".x64.imm"},        if64.out_imm, 64'h0);
    chk({tag, ".x32n.out_valid"}, 64'(if32n.out_valid), 64'h0);
    chk({tag, ".x32n.in_ready"},  64'(if32n.in_ready), 64'h1);
  endtask

  function automatic logic [31:0] rand_ir();
    logic [31:0] r = $urandom;
    logic [6:0]  op;
    case ($urandom_range(0, 11))
      0:  op = 7'b0110111;
      1:  op = 7'b0010111;
      2:  op = 7'b1101111;
      3:  op = 7'b1100011;
      4:  op = 7'b0100011;
      5:  op = 7'b1100111;
      6:  op = 7'b0000011;
      7:  op = 7'b0010011;
      8:  op = 7'b0011011;
      9:  op = 7'b1110011;
      10: op = 7'b0110011;
      default: op = r[6:0];
    endcase
    return {r[31:7], op};
  endfunction

  typedef struct {
    logic [31:0] ir;
    logic [63:0] i32; logic [2:0] f32; logic l32;
    logic [63:0] i64; logic [2:0] f64; logic l64;
    logic [63:0] in;  logic [2:0] fn;  logic ln;
  } vec_t;

  vec_t tbl[8];
  int a0, o0;
  logic [31:0] w0, w1, w2;

  initial begin
    tbl = '{
      '{32'h12345037, 64'h12345000, 3'd4, 1'b0, 64'h12345000, 3'd4, 1'b0, 64'h12345000, 3'd4, 1'b0},
      '{32'hFFDFF0EF, 64'hFFFFFFFC, 3'd5, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0, 64'hFFFFFFFC, 3'd5, 1'b0},
      '{32'hFE000CE3, 64'hFFFFFFF8, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0, 64'hFFFFFFF8, 3'd3, 1'b0},
      '{32'h800000B7, 64'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0, 64'h80000000, 3'd4, 1'b0},
      '{32'h4030D093, 64'h3, 3'd6, 1'b0, 64'h3, 3'd6, 1'b0, 64'h3, 3'd6, 1'b0},
      '{32'h02009093, 64'h20, 3'd6, 1'b1, 64'h20, 3'd6, 1'b0, 64'h20, 3'd6, 1'b1},
      '{32'h3002D0F3, 64'h5, 3'd7, 1'b0, 64'h5, 3'd7, 1'b0, 64'h0, 3'd0, 1'b0},
      '{32'h0200909B, 64'h0, 3'd0, 1'b0, 64'h0, 3'd6, 1'b1, 64'h0, 3'd0, 1'b0}
    };
    rst = 1'b1;
    in_valid = 1'b0;
    in_ir = 32'h0;
    out_ready = 1'b0;
    #1;
    reset_chk("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // directed vectors, one at a time, checked against hand-derived constants
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, tbl[i].ir, 1'b1);
      drive_cycle(1'b0, 32'h0, 1'b1);
      chk($sformatf("tbl%0d.x32.imm", i),  {32'h0, if32.out_imm}, tbl[i].i32);
      chk($sformatf("tbl%0d.x32.fmt", i),  64'(if32.out_fmt), 64'(tbl[i].f32));
      chk($sformatf("tbl%0d.x32.ill", i),  64'(if32.out_illegal), 64'(tbl[i].l32));
      chk($sformatf("tbl%0d.x64.imm", i),  if64.out_imm, tbl[i].i64);
      chk($sformatf("tbl%0d.x64.fmt", i),  64'(if64.out_fmt), 64'(tbl[i].f64));
      chk($sformatf("tbl%0d.x64.ill", i),  64'(if64.out_illegal), 64'(tbl[i].l64));
      chk($sformatf("tbl%0d.x32n.imm", i), {32'h0, if32n.out_imm}, tbl[i].in);
      chk($sformatf("tbl%0d.x32n.fmt", i), 64'(if32n.out_fmt), 64'(tbl[i].fn));
      chk($sformatf("tbl%0d.x32n.ill", i), 64'(if32n.out_illegal), 64'(tbl[i].ln));
    end

    // back-to-back stream without stall
    drive_cycle(1'b1, 32'h12345037, 1'b1);
    drive_cycle(1'b1, 32'hFFDFF0EF, 1'b1);
    drive_cycle(1'b1, 32'hFE000CE3, 1'b1);
    drive_cycle(1'b0, 32'h0, 1'b1);
    drive_cycle(1'b0, 32'h0, 1'b1);

    // backpressure: three words presented, only two fit
    w0 = rand_ir(); w1 = rand_ir(); w2 = rand_ir();
    a0 = dut_acc;
    o0 = dut_out;
    drive_cycle(1'b1, w0, 1'b0);
    drive_cycle(1'b1, w1, 1'b0);
    drive_cycle(1'b1, w2, 1'b0);
    drive_cycle(1'b1, w2, 1'b0);
    chk("bp.accepted", 64'(dut_acc - a0), 64'd2);
    chk("bp.in_ready_low", 64'(if32.in_ready), 64'd0);
    drive_cycle(1'b1, w2, 1'b1);
    drive_cycle(1'b1, w2, 1'b1);
    drive_cycle(1'b0, 32'h0, 1'b1);
    drive_cycle(1'b0, 32'h0, 1'b1);
    chk("bp.drained", 64'(dut_out - o0), 64'd3);
    chk("bp.accepted_all", 64'(dut_acc - a0), 64'd3);

    // randomized traffic with random backpressure
    for (int i = 0; i < 400; i++)
      drive_cycle(1'($urandom_range(0, 3) != 0), rand_ir(), 1'($urandom_range(0, 3) != 0));
    repeat (3) drive_cycle(1'b0, 32'h0, 1'b1);

    // asynchronous reset with M and K both occupied
    drive_cycle(1'b1, rand_ir(), 1'b0);
    drive_cycle(1'b1, rand_ir(), 1'b0);
    drive_cycle(1'b0, 32'h0, 1'b0);
    chk("pre_rst.in_ready", 64'(if32.in_ready), 64'd0);
    #1;
    rst = 1'b1;
    #1;
    reset_chk("async");
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive_cycle(1'b0, 32'h0, 1'b1);
    drive_cycle(1'b0, 32'h0, 1'b1);
    drive_cycle(1'b1, 32'h4030D093, 1'b1);
    drive_cycle(1'b0, 32'h0, 1'b1);
    chk("post_rst.imm", {32'h0, if32.out_imm}, 64'h3);
    drive_cycle(1'b0, 32'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. It accepts one 32-bit instruction word per cycle over a valid/ready handshake and returns the sign- or zero-extended immediate at XLEN width. It also returns an encoding-format tag and an illegal-shamt flag. A 2-entry skid buffer gives full throughput under downstream backpressure. It sits between the fetch queue and the register-read/ALU-operand mux, and serves RV32I and RV64I cores from one source.

## Interface
- XLEN, 32: output data width; legal values 32 or 64; any other value is an elaboration error.
- ZIMM_EN, 1: 1 = decode the CSR immediate (zimm); 0 = SYSTEM opcode yields format NONE.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  in_ir carries an instruction.
- in_ready  out  1  block can accept; transfer occurs when in_valid && in_ready.
- in_ir  in  32  instruction word.
- out_valid  out  1  out_imm/out_fmt/out_illegal are valid.
- out_ready  in  1  consumer accepts; transfer occurs when out_valid && out_ready.
- out_imm  out  XLEN  extended immediate.
- out_fmt  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM.
- out_illegal  out  1  shamt out of range for XLEN.

## Operation
- Decode key is opcode ir[6:0]:
  - LUI 0110111 / AUIPC 0010111 -> U: {ir[31:12], 12'h0}. Bits above 31 replicate ir[31].
  - JAL 1101111 -> J: sext({ir[31], ir[19:12], ir[20], ir[30:21], 0}).
  - BRANCH 1100011 -> B: sext({ir[31], ir[7], ir[30:25], ir[11:8], 0}).
  - STORE 0100011 -> S: sext({ir[31:25], ir[11:7]}).
  - JALR 1100111, LOAD 0000011 -> I: sext(ir[31:20]).
- OP-IMM 0010011:
  - funct3 001/101 -> SHAMT: zero-extended ir[25:20].
    - XLEN=32 with ir[25]=1 -> out_illegal=1; imm is still ir[25:20].
  - All other funct3 -> I.
- OP-IMM-32 0011011:
  - Decoded only when XLEN=64; when XLEN=32 it is treated as an unrecognised opcode (format NONE, as below).
  - funct3 001/101 -> SHAMT from ir[24:20]; out_illegal = ir[25].
  - All other funct3 -> I.
- SYSTEM 1110011 with funct3[2]=1 and ZIMM_EN=1 -> ZIMM: zero-extended ir[19:15].
- Any other opcode, including SYSTEM with funct3[2]=0 -> imm 0, fmt NONE, illegal 0.
- "sext" always means sign extension from ir[31] to XLEN bits.
- Datapath structure:
  - Decode is combinational on in_ir.
  - The result is captured into the main output register, M.
  - A single skid register, K, holds one extra result.
- Skid buffer rules (mv/kv = valid bits of M and K):
  - in_ready = !kv.
  - out_valid = mv; outputs always drive M.
  - Accept while (!mv || out_ready): the new result loads M.
  - Accept while mv && !out_ready: the new result loads K; kv=1.
  - Output transfer with kv=1: K moves to M, kv=0. A simultaneous accept is impossible because in_ready=0.
  - Output transfer with kv=0 and no accept: mv=0.
- Ordering is strictly FIFO. There are no drops and no duplicates.

## Timing
- Latency: 1 cycle from input transfer to out_valid (result in M on the next edge).
- Throughput: 1 instruction per cycle while out_ready=1.
- in_ready is a pure register output (!kv), with no combinational path from out_ready.
- Reset (asynchronous, takes effect without a clock edge):
  - mv=kv=0, out_valid=0, in_ready=1.
  - out_imm=0, out_fmt=0, out_illegal=0; K data=0.
- Reset asserted mid-stream discards M and K contents. The first accept after reset deassertion appears 1 cycle later.
- Data in M holds stable while out_valid && !out_ready.
- in_valid low with an empty buffer: outputs keep their last values with out_valid=0.

## Test plan
- XLEN=32, stream without stall:
  - LUI 0x12345037 -> imm 0x12345000, fmt 4.
  - JAL 0xFFDFF0EF -> 0xFFFFFFFC, fmt 5.
  - BEQ 0xFE000CE3 -> 0xFFFFFFF8, fmt 3.
  - Expect one result per cycle, each 1 cycle after its input.
- XLEN=64: LUI 0x800000B7 -> 0xFFFFFFFF80000000.
- Shift decode:
  - SRAI 0x4030D093 -> imm 3, fmt 6, illegal 0.
  - SLLI 0x02009093 -> imm 32; illegal 1 at XLEN=32, illegal 0 at XLEN=64.
- CSRRWI 0x3002D0F3:
  - ZIMM_EN=1 -> imm 5, fmt 7.
  - ZIMM_EN=0 -> imm 0, fmt 0.
- Backpressure:
  - Hold out_ready=0 and present 3 valid words back-to-back.
  - Expect 2 accepted and in_ready=0 from the cycle after the second accept.
  - Raise out_ready: all 3 results emerge in order, with no gaps once draining.
- Reset:
  - Assert rst asynchronously with M and K both full.
  - Expect out_valid=0 and in_ready=1 immediately, all outputs 0, and no stale result after release.
